// File: rtl/neopixel_chain_driver_if.sv
// Handshake and data bundle between a framebuffer owner (master) and the
// neopixel chain driver (slave).
interface neopixel_chain_driver_if #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24
);
  logic [NUM_LEDS*BITS_PER_LED-1:0] framebuf;
  logic                             start;
  logic                             auto_refresh;
  logic                             busy;
  logic                             frame_done;
  logic                             data;

  modport master (
    output framebuf, start, auto_refresh,
    input  busy, frame_done, data
  );

  modport slave (
    input  framebuf, start, auto_refresh,
    output busy, frame_done, data
  );
endinterface

// File: rtl/neopixel_chain_driver.sv
// Serialises a snapshotted NUM_LEDS-pixel framebuffer onto one neopixel line,
// with cycle-count bit timing, a latch gap and optional auto-refresh.
module neopixel_chain_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T_BIT        = 25,
  parameter int T0H          = 8,
  parameter int T1H          = 16,
  parameter int T_RESET      = 1600
) (
  input logic                   clk,
  input logic                   nrst,
  neopixel_chain_driver_if.slave bus
);
  localparam int FB_W  = NUM_LEDS * BITS_PER_LED;
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam int PH_W  = $clog2(T_BIT);
  localparam int LAT_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;

  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(BITS_PER_LED - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0]  T0H_C    = PH_W'(T0H);
  localparam logic [PH_W-1:0]  T1H_C    = PH_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RESET - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BITS  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [LED_W-1:0]  led_cnt, led_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [LAT_W-1:0]  lat_cnt, lat_nx;
  logic [FB_W-1:0]   snap;
  logic              load, shift, trigger, cur_bit;
  logic              data_nx, busy_nx, done_nx;

  // Next-state, counter and output decode; outputs are registered one cycle later.
  always_comb begin
    state_nx = state;
    led_nx   = led_cnt;
    bit_nx   = bit_cnt;
    phase_nx = phase;
    lat_nx   = lat_cnt;
    load     = 1'b0;
    shift    = 1'b0;
    trigger  = bus.start | bus.auto_refresh;
    // The snapshot shifts down one LED at a time, so the current LED is always at the bottom.
    cur_bit  = snap[bit_cnt];

    case (state)
      IDLE: begin
        if (trigger) begin
          load     = 1'b1;
          state_nx = BITS;
          phase_nx = {PH_W{1'b0}};
          bit_nx   = BIT_TOP;
          led_nx   = {LED_W{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      BITS: begin
        if (phase == PH_LAST) begin
          phase_nx = {PH_W{1'b0}};
          if (bit_cnt == {BIT_W{1'b0}}) begin
            if (led_cnt == LED_LAST) begin
              state_nx = LATCH;
              lat_nx   = {LAT_W{1'b0}};
            end else begin
              shift  = 1'b1;
              led_nx = led_cnt + LED_W'(1);
              bit_nx = BIT_TOP;
            end
          end else begin
            bit_nx = bit_cnt - BIT_W'(1);
          end
        end else begin
          phase_nx = phase + PH_W'(1);
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) begin
          if (trigger) begin
            load     = 1'b1;
            state_nx = BITS;
            phase_nx = {PH_W{1'b0}};
            bit_nx   = BIT_TOP;
            led_nx   = {LED_W{1'b0}};
          end else begin
            state_nx = IDLE;
          end
        end else begin
          lat_nx = lat_cnt + LAT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (state == BITS) begin
      data_nx = (phase < (cur_bit ? T1H_C : T0H_C));
    end else begin
      data_nx = 1'b0;
    end
    busy_nx = (state != IDLE);
    done_nx = (state == LATCH) && (lat_cnt == LAT_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      led_cnt        <= {LED_W{1'b0}};
      bit_cnt        <= {BIT_W{1'b0}};
      phase          <= {PH_W{1'b0}};
      lat_cnt        <= {LAT_W{1'b0}};
      bus.data       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nx;
      led_cnt        <= led_nx;
      bit_cnt        <= bit_nx;
      phase          <= phase_nx;
      lat_cnt        <= lat_nx;
      bus.data       <= data_nx;
      bus.busy       <= busy_nx;
      bus.frame_done <= done_nx;
    end
  end

  // Framebuffer snapshot, frozen for the frame in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      snap <= {FB_W{1'b0}};
    end else if (load) begin
      snap <= bus.framebuf;
    end else if (shift) begin
      snap <= snap >> BITS_PER_LED;
    end else begin
      snap <= snap;
    end
  end
endmodule
